// File: rtl/i2s_sample_fifo.sv
// Sample FIFO between the i2s controller and a valid/ready consumer.
// Truncates each word to its sample MSBs, buffers (left,right) pairs, and counts dropped frames.
module i2s_sample_fifo #(
    parameter int bits_per_word  = 32,
    parameter int sample_width   = 24,
    parameter int fifo_depth     = 16,
    parameter int drop_cnt_width = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [bits_per_word-1:0]        in_data_0,
    input  logic [bits_per_word-1:0]        in_data_1,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [sample_width-1:0]         out_data_0,
    output logic [sample_width-1:0]         out_data_1,
    output logic [$clog2(fifo_depth):0]     fill_level,
    output logic                            overflow,
    input  logic                            clear_overflow,
    output logic [drop_cnt_width-1:0]       drop_count
);

    localparam int RAM_DEPTH = fifo_depth - 1;
    localparam int PTR_W     = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int CNT_W     = $clog2(fifo_depth) + 1;
    localparam logic [PTR_W-1:0]          PTR_LAST = PTR_W'(RAM_DEPTH - 1);
    localparam logic [CNT_W-1:0]          RAM_FULL = CNT_W'(RAM_DEPTH);
    localparam logic [drop_cnt_width-1:0] DROP_MAX = '1;

    typedef struct packed {
        logic [sample_width-1:0] left;
        logic [sample_width-1:0] right;
    } pair_t;

    pair_t                      ram [RAM_DEPTH];
    pair_t                      in_pair;
    pair_t                      out_pair_q, out_pair_d;
    logic                       out_valid_q, out_valid_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           ram_cnt_q, ram_cnt_d;
    logic                       overflow_q, overflow_d;
    logic [drop_cnt_width-1:0]  drop_cnt_q, drop_cnt_d;
    logic                       ram_we;
    logic                       pop, full, drop, accept;

    // Discarded LSBs are intentionally unread; folding them here keeps the intent explicit.
    logic unused_lsbs;
    assign unused_lsbs = ^{in_data_0, in_data_1};

    assign in_pair = '{left:  in_data_0[bits_per_word-1 -: sample_width],
                       right: in_data_1[bits_per_word-1 -: sample_width]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        out_pair_d  = out_pair_q;
        out_valid_d = out_valid_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        ram_cnt_d   = ram_cnt_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;
        ram_we      = 1'b0;

        pop    = out_valid_q && out_ready;
        full   = out_valid_q && (ram_cnt_q == RAM_FULL);
        drop   = in_valid && full && !pop;
        accept = in_valid && !drop;

        // The RAM is only ever non-empty while the output stage holds a pair.
        if (!out_valid_q) begin
            if (accept) begin
                out_pair_d  = in_pair;
                out_valid_d = 1'b1;
            end
        end else if (pop) begin
            if (ram_cnt_q != '0) begin
                out_pair_d = ram[rd_ptr_q];
                rd_ptr_d   = ptr_inc(rd_ptr_q);
                if (accept) begin
                    ram_we   = 1'b1;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                end else begin
                    ram_cnt_d = ram_cnt_q - 1'b1;
                end
            end else if (accept) begin
                out_pair_d = in_pair;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            ram_we    = 1'b1;
            wr_ptr_d  = ptr_inc(wr_ptr_q);
            ram_cnt_d = ram_cnt_q + 1'b1;
        end

        // A drop in the clearing cycle counts as the first drop after the clear.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow)
                drop_cnt_d = drop_cnt_width'(1);
            else if (drop_cnt_q != DROP_MAX)
                drop_cnt_d = drop_cnt_q + 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            out_pair_q  <= '0;
            out_valid_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            out_pair_q  <= out_pair_d;
            out_valid_q <= out_valid_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // NOTE: storage array is not reset; cleared pointers and count make its contents irrelevant.
    always_ff @(posedge clock) begin
        if (ram_we)
            ram[wr_ptr_q] <= in_pair;
    end

    assign out_valid  = out_valid_q;
    assign out_data_0 = out_pair_q.left;
    assign out_data_1 = out_pair_q.right;
    assign fill_level = ram_cnt_q + CNT_W'(out_valid_q);
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

endmodule
